// File: rtl/instr_fetch.sv
// Instruction fetch stage: a small IDLE/RUN/HALT sequencer that walks the PC
// through instruction memory, registers the fetched word for decode, honours
// stall and redirect requests, and stops on a HALT opcode until reset.
module instr_fetch #(
    parameter int         ADDR_W  = 8,
    parameter int         INSTR_W = 16,
    parameter logic [4:0] OP_NOP  = 5'b00000,
    parameter logic [4:0] OP_HALT = 5'b00001
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               stall,
    input  logic               jump_valid,
    input  logic [ADDR_W-1:0]  jump_addr,
    output logic [ADDR_W-1:0]  i_addr,
    input  logic [INSTR_W-1:0] i_datain,
    output logic [INSTR_W-1:0] id_ir,
    output logic [ADDR_W-1:0]  id_pc,
    output logic               id_valid,
    output logic               halted
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    // Bubble inserted into decode whenever no real instruction is delivered.
    localparam logic [INSTR_W-1:0] NOP_WORD = INSTR_W'({OP_NOP, 11'b000_0000_0000});
    localparam logic [ADDR_W-1:0]  PC_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t               state_r;
    state_t               state_nxt_s;
    logic [ADDR_W-1:0]    pc_r;
    logic [ADDR_W-1:0]    pc_nxt_s;
    logic [INSTR_W-1:0]   ir_r;
    logic [INSTR_W-1:0]   ir_nxt_s;
    logic [ADDR_W-1:0]    id_pc_r;
    logic [ADDR_W-1:0]    id_pc_nxt_s;
    logic                 valid_r;
    logic                 valid_nxt_s;
    logic                 halted_r;
    logic                 halted_nxt_s;
    logic [4:0]           opcode_s;

    assign opcode_s = i_datain[15:11];

    // Next-state and next-register values for the whole fetch stage.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        ir_nxt_s    = ir_r;
        id_pc_nxt_s = id_pc_r;
        valid_nxt_s = valid_r;

        case (state_r)
            IDLE: begin
                ir_nxt_s    = NOP_WORD;
                valid_nxt_s = 1'b0;
                if (enable) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (jump_valid) begin
                    // Redirect wins over stall, HALT fetch and pause; the
                    // FSM still drops to IDLE if enable is low.
                    pc_nxt_s    = jump_addr;
                    ir_nxt_s    = NOP_WORD;
                    valid_nxt_s = 1'b0;
                    if (enable) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else if (!enable) begin
                    state_nxt_s = IDLE;
                    ir_nxt_s    = NOP_WORD;
                    valid_nxt_s = 1'b0;
                end else if (stall) begin
                    state_nxt_s = RUN;
                end else if (opcode_s == OP_HALT) begin
                    // The HALT word itself goes to decode; pc stays on it.
                    state_nxt_s = HALT;
                    ir_nxt_s    = i_datain;
                    id_pc_nxt_s = pc_r;
                    valid_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = RUN;
                    ir_nxt_s    = i_datain;
                    id_pc_nxt_s = pc_r;
                    valid_nxt_s = 1'b1;
                    pc_nxt_s    = pc_r + PC_ONE;
                end
            end
            HALT: begin
                state_nxt_s = HALT;
                ir_nxt_s    = NOP_WORD;
                valid_nxt_s = 1'b0;
            end
            default: begin
                state_nxt_s = IDLE;
                ir_nxt_s    = NOP_WORD;
                valid_nxt_s = 1'b0;
            end
        endcase

        halted_nxt_s = (state_nxt_s == HALT);
    end

    // State and pipeline registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r  <= IDLE;
            pc_r     <= {ADDR_W{1'b0}};
            ir_r     <= {INSTR_W{1'b0}};
            id_pc_r  <= {ADDR_W{1'b0}};
            valid_r  <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            pc_r     <= pc_nxt_s;
            ir_r     <= ir_nxt_s;
            id_pc_r  <= id_pc_nxt_s;
            valid_r  <= valid_nxt_s;
            halted_r <= halted_nxt_s;
        end
    end

    assign i_addr   = pc_r;
    assign id_ir    = ir_r;
    assign id_pc    = id_pc_r;
    assign id_valid = valid_r;
    assign halted   = halted_r;

endmodule
